// File: rtl/para_to_serial_hs_if.sv
// Handshake bundle for para_to_serial_hs: parallel block input stream and serial word output stream.
// The converter connects through the slave modport; the producer/consumer side uses master.
interface para_to_serial_hs_if #(
  parameter int IN_W  = 256,
  parameter int OUT_W = 32
);
  localparam int CNT_W = $clog2(IN_W / OUT_W);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;
  logic [CNT_W-1:0] out_idx;
  logic             busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_idx, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, out_idx, busy
  );
endinterface

// File: rtl/para_to_serial_hs.sv
// Handshaked parallel-to-serial converter: one IN_W block out as IN_W/OUT_W words of OUT_W bits.
// Define PTS_DBLBUF_EN to add a pending block register so back-to-back blocks stream without a bubble.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no block held, ready to accept
// ST_SHIFT | emitting word idx of the held block, waiting on out_ready
module para_to_serial_hs #(
  parameter int IN_W      = 256,
  parameter int OUT_W     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  para_to_serial_hs_if.slave   bus
);
  localparam int N     = IN_W / OUT_W;
  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(N - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [IN_W-1:0]  hold_q, hold_d;
`ifdef PTS_DBLBUF_EN
  logic [IN_W-1:0]  pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
`endif

  logic             shifting;
  logic             in_ready_int;
  logic             accept;
  logic             beat;
  logic [CNT_W-1:0] sel;
  logic [31:0]      base;

  assign shifting = (state_q == ST_SHIFT);
`ifdef PTS_DBLBUF_EN
  assign in_ready_int = !pend_full_q;
`else
  assign in_ready_int = (state_q == ST_IDLE);
`endif
  assign accept = bus.in_valid && in_ready_int;
  assign beat   = shifting && bus.out_ready;

  // Word 0 is the top slice when MSB_FIRST, so the slice index runs backwards.
  always_comb begin
    sel  = MSB_FIRST ? (IDX_LAST - idx_q) : idx_q;
    base = 32'(sel) * 32'(OUT_W);
  end

  assign bus.in_ready  = in_ready_int && !rst;
  assign bus.out_valid = shifting;
  assign bus.busy      = shifting;
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = shifting && (idx_q == IDX_LAST);
  assign bus.out_data  = shifting ? hold_q[base +: OUT_W] : '0;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
`ifdef PTS_DBLBUF_EN
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          hold_d  = bus.in_data;
          idx_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
`ifdef PTS_DBLBUF_EN
        if (beat && (idx_q == IDX_LAST)) begin
          idx_d = '0;
          if (pend_full_q) begin
            hold_d      = pend_q;
            pend_full_d = 1'b0;
          end else if (accept) begin
            hold_d = bus.in_data;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          if (beat) idx_d = idx_q + 1'b1;
          if (accept) begin
            pend_d      = bus.in_data;
            pend_full_d = 1'b1;
          end
        end
`else
        if (beat) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
`ifdef PTS_DBLBUF_EN
      pend_q      <= '0;
      pend_full_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
`ifdef PTS_DBLBUF_EN
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
`endif
    end
  end
endmodule

// File: tb/tb_para_to_serial_hs.sv
// Directed bench for para_to_serial_hs: a 256->32 MSB-first instance and a 64->8 LSB-first instance.
// Expected words are computed from the block pattern; second-block behaviour follows PTS_DBLBUF_EN.
module tb_para_to_serial_hs;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   beats;

  para_to_serial_hs_if #(.IN_W(256), .OUT_W(32)) bus_a ();
  para_to_serial_hs_if #(.IN_W(64),  .OUT_W(8))  bus_b ();

  para_to_serial_hs #(.IN_W(256), .OUT_W(32), .MSB_FIRST(1'b1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  para_to_serial_hs #(.IN_W(64), .OUT_W(8), .MSB_FIRST(1'b0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word i of the block (bits i*32 +: 32) holds base+i, so MSB-first word k is base+7-k.
  function automatic logic [255:0] mk(input logic [31:0] base);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = base + 32'(i);
    return v;
  endfunction

  initial begin
    rst             = 1'b1;
    bus_a.in_valid  = 1'b0;
    bus_a.in_data   = '0;
    bus_a.out_ready = 1'b1;
    bus_b.in_valid  = 1'b0;
    bus_b.in_data   = '0;
    bus_b.out_ready = 1'b1;

    #3;
    chk("rst_out_valid", bus_a.out_valid, 0);
    chk("rst_busy",      bus_a.busy,      0);
    chk("rst_out_idx",   bus_a.out_idx,   0);
    chk("rst_out_data",  bus_a.out_data,  0);
    chk("rst_out_last",  bus_a.out_last,  0);
    chk("rst_in_ready",  bus_a.in_ready,  0);

    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rel_in_ready",  bus_a.in_ready,  1);
    chk("rel_out_valid", bus_a.out_valid, 0);

    // Single block, consumer always ready
    bus_a.in_data  = mk(32'h0);
    bus_a.in_valid = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("t1_valid", bus_a.out_valid, 1);
      chk("t1_busy",  bus_a.busy,      1);
      chk("t1_data",  bus_a.out_data,  7 - k);
      chk("t1_idx",   bus_a.out_idx,   k);
      chk("t1_last",  bus_a.out_last,  (k == 7) ? 1 : 0);
      tick();
    end
    chk("t1_end_valid",    bus_a.out_valid, 0);
    chk("t1_end_in_ready", bus_a.in_ready,  1);
    chk("t1_end_busy",     bus_a.busy,      0);

    // Backpressure for 3 cycles at idx 2
    bus_a.in_data  = mk(32'h0);
    bus_a.in_valid = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    beats = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        bus_a.out_ready = 1'b0;
        for (int h = 0; h < 3; h++) begin
          chk("bp_hold_valid", bus_a.out_valid, 1);
          chk("bp_hold_data",  bus_a.out_data,  5);
          chk("bp_hold_idx",   bus_a.out_idx,   2);
          tick();
        end
        bus_a.out_ready = 1'b1;
      end
      chk("bp_data", bus_a.out_data, 7 - k);
      chk("bp_idx",  bus_a.out_idx,  k);
      if (bus_a.out_valid && bus_a.out_ready) beats++;
      tick();
    end
    chk("bp_beats",     beats,           8);
    chk("bp_end_valid", bus_a.out_valid, 0);

`ifdef PTS_DBLBUF_EN
    // Two blocks back-to-back stream as 16 contiguous beats
    bus_a.in_data  = mk(32'h100);
    bus_a.in_valid = 1'b1;
    tick();
    bus_a.in_data  = mk(32'h200);
    for (int j = 0; j < 16; j++) begin
      if (j == 1) chk("db_in_ready_full", bus_a.in_ready, 0);
      chk("db_valid", bus_a.out_valid, 1);
      chk("db_data",  bus_a.out_data,  (j < 8) ? (32'h107 - 32'(j)) : (32'h20f - 32'(j)));
      chk("db_idx",   bus_a.out_idx,   j % 8);
      chk("db_last",  bus_a.out_last,  (j == 7 || j == 15) ? 1 : 0);
      tick();
      if (j == 0) bus_a.in_valid = 1'b0;
    end
    chk("db_end_valid", bus_a.out_valid, 0);
`else
    // Second block offered during SHIFT waits for IDLE
    bus_a.in_data  = mk(32'h100);
    bus_a.in_valid = 1'b1;
    tick();
    bus_a.in_data  = mk(32'h200);
    for (int k = 0; k < 8; k++) begin
      chk("b2_in_ready_shift", bus_a.in_ready, 0);
      chk("b2_first_data",     bus_a.out_data, 32'h107 - 32'(k));
      chk("b2_first_last",     bus_a.out_last, (k == 7) ? 1 : 0);
      tick();
    end
    chk("b2_accept_ready", bus_a.in_ready,  1);
    chk("b2_gap_valid",    bus_a.out_valid, 0);
    tick();
    bus_a.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("b2_second_data", bus_a.out_data, 32'h207 - 32'(k));
      chk("b2_second_idx",  bus_a.out_idx,  k);
      tick();
    end
    chk("b2_end_valid", bus_a.out_valid, 0);
`endif

    // Reset in the middle of a block
    bus_a.in_data  = mk(32'h300);
    bus_a.in_valid = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("mr_pre_idx",  bus_a.out_idx,  4);
    chk("mr_pre_data", bus_a.out_data, 32'h303);
    #2 rst = 1'b1;
    #1;
    chk("mr_valid",    bus_a.out_valid, 0);
    chk("mr_idx",      bus_a.out_idx,   0);
    chk("mr_busy",     bus_a.busy,      0);
    chk("mr_in_ready", bus_a.in_ready,  0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    bus_a.in_data  = mk(32'h400);
    bus_a.in_valid = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("mr_new_data", bus_a.out_data, 32'h407 - 32'(k));
      chk("mr_new_idx",  bus_a.out_idx,  k);
      tick();
    end

    // 64 -> 8, LSB first
    bus_b.in_data  = 64'h0706050403020100;
    bus_b.in_valid = 1'b1;
    tick();
    bus_b.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("lsb_valid", bus_b.out_valid, 1);
      chk("lsb_data",  bus_b.out_data,  k);
      chk("lsb_idx",   bus_b.out_idx,   k);
      chk("lsb_last",  bus_b.out_last,  (k == 7) ? 1 : 0);
      tick();
    end
    chk("lsb_end_valid",    bus_b.out_valid, 0);
    chk("lsb_end_in_ready", bus_b.in_ready,  1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
